// File: rtl/dcache_arbiter.sv
// rtl/dcache_arbiter.sv - store/load arbiter in front of the DCache with single outstanding miss tracking
module dcache_arbiter #(
  parameter int LSQSZ        = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     st_req,
  input  logic [15:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [1:0]               st_size,
  output logic                     st_ack,

  input  logic                     ld_req,
  input  logic [$clog2(LSQSZ)-1:0] ld_lq_idx,
  input  logic [15:0]              ld_addr,
  input  logic [1:0]               ld_size,
  output logic                     ld_ack,

  output logic                     wr_en,
  output logic [7:0]               wr_tag,
  output logic [4:0]               wr_idx,
  output logic [2:0]               wr_offset,
  output logic [31:0]              wr_data,
  output logic [1:0]               wr_size,

  output logic                     rd_en,
  output logic [7:0]               rd_tag,
  output logic [4:0]               rd_idx,
  output logic [2:0]               rd_offset,
  output logic [1:0]               rd_size,
  output logic [LSQSZ-1:0]         rd_gnt,
  input  logic                     dc_hit,

  output logic                     mem_req,
  output logic [15:0]              mem_addr,
  input  logic                     mem_ack,

  input  logic                     except,
  output logic [LSQSZ-1:0]         dc_feedback,
  output logic [LSQSZ-1:0]         mem_feedback
);

  localparam int IDXW = $clog2(LSQSZ);
  localparam int CW   = $clog2(STARVE_LIMIT) + 1;
  localparam logic [LSQSZ-1:0] ONE = LSQSZ'(1);
  localparam logic [CW-1:0]    STARVE_MAX = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MISS  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   starve_cnt;
  logic [CW-1:0]   starve_nxt;
  logic [IDXW-1:0] miss_idx;
  logic [15:0]     miss_addr;

  logic load_ok;
  logic starved;
  logic st_grant;
  logic ld_grant;
  logic miss_start;

  // Arbitration: stores win by default, a load that has lost STARVE_LIMIT
  // times in a row takes the cycle. Everything is gated by rst_n so that
  // outputs read zero while reset is held, whatever the inputs do.
  always_comb begin
    load_ok    = rst_n && (state == IDLE) && ld_req && !except;
    starved    = load_ok && (starve_cnt == STARVE_MAX);
    st_grant   = rst_n && st_req && !starved;
    ld_grant   = load_ok && !st_grant;
    miss_start = ld_grant && !dc_hit;
  end

  // Starve counter: counts consecutive losses of a grantable load, and is
  // cleared once the load wins or the load request goes away.
  always_comb begin
    starve_nxt = starve_cnt;
    if (ld_grant || !ld_req) begin
      starve_nxt = '0;
    end else if (load_ok && st_grant) begin
      starve_nxt = starve_cnt + CW'(1);
    end
  end

  // Next-state logic for the single outstanding miss, plus the miss fill
  // feedback, which is suppressed when the miss was squashed by a flush.
  always_comb begin
    state_nxt    = state;
    mem_feedback = '0;
    case (state)
      IDLE: begin
        if (miss_start) begin
          state_nxt = MISS;
        end
      end
      MISS: begin
        if (mem_ack) begin
          if (!except) begin
            mem_feedback = ONE << miss_idx;
          end
          state_nxt = IDLE;
        end else if (except) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // DCache port drive: address fields are only presented on the granted path.
  always_comb begin
    st_ack      = 1'b0;
    wr_en       = 1'b0;
    wr_tag      = '0;
    wr_idx      = '0;
    wr_offset   = '0;
    wr_data     = '0;
    wr_size     = '0;
    ld_ack      = 1'b0;
    rd_en       = 1'b0;
    rd_tag      = '0;
    rd_idx      = '0;
    rd_offset   = '0;
    rd_size     = '0;
    rd_gnt      = '0;
    dc_feedback = '0;
    if (st_grant) begin
      st_ack    = 1'b1;
      wr_en     = 1'b1;
      wr_tag    = st_addr[15:8];
      wr_idx    = st_addr[7:3];
      wr_offset = st_addr[2:0];
      wr_data   = st_data;
      wr_size   = st_size;
    end
    if (ld_grant) begin
      ld_ack    = 1'b1;
      rd_en     = 1'b1;
      rd_tag    = ld_addr[15:8];
      rd_idx    = ld_addr[7:3];
      rd_offset = ld_addr[2:0];
      rd_size   = ld_size;
      rd_gnt    = ONE << ld_lq_idx;
      if (dc_hit) begin
        dc_feedback = ONE << ld_lq_idx;
      end
    end
  end

  // Memory request is live for the whole miss, including a squashed one
  // that still has to see its mem_ack before the next miss can start.
  always_comb begin
    mem_req  = rst_n && (state != IDLE);
    mem_addr = rst_n ? miss_addr : 16'h0000;
  end

  // State, starve counter and the latched miss entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      miss_idx   <= '0;
      miss_addr  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (miss_start) begin
        miss_idx  <= ld_lq_idx;
        miss_addr <= ld_addr;
      end
    end
  end

endmodule

// File: tb/tb_dcache_arbiter.sv
// tb/tb_dcache_arbiter.sv - directed and randomized checks of dcache_arbiter against a behavioural model
module tb_dcache_arbiter;

  localparam int LSQSZ        = 16;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_req;
  logic [15:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_ack;
  logic        ld_req;
  logic [3:0]  ld_lq_idx;
  logic [15:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_ack;
  logic        wr_en;
  logic [7:0]  wr_tag;
  logic [4:0]  wr_idx;
  logic [2:0]  wr_offset;
  logic [31:0] wr_data;
  logic [1:0]  wr_size;
  logic        rd_en;
  logic [7:0]  rd_tag;
  logic [4:0]  rd_idx;
  logic [2:0]  rd_offset;
  logic [1:0]  rd_size;
  logic [15:0] rd_gnt;
  logic        dc_hit;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic        except;
  logic [15:0] dc_feedback;
  logic [15:0] mem_feedback;

  int errors = 0;
  int checks = 0;

  dcache_arbiter #(.LSQSZ(LSQSZ), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size), .st_ack(st_ack),
    .ld_req(ld_req), .ld_lq_idx(ld_lq_idx), .ld_addr(ld_addr), .ld_size(ld_size), .ld_ack(ld_ack),
    .wr_en(wr_en), .wr_tag(wr_tag), .wr_idx(wr_idx), .wr_offset(wr_offset), .wr_data(wr_data), .wr_size(wr_size),
    .rd_en(rd_en), .rd_tag(rd_tag), .rd_idx(rd_idx), .rd_offset(rd_offset), .rd_size(rd_size), .rd_gnt(rd_gnt),
    .dc_hit(dc_hit), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .except(except), .dc_feedback(dc_feedback), .mem_feedback(mem_feedback)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    st_req = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    ld_req = 1'b0; ld_lq_idx = '0; ld_addr = '0; ld_size = '0;
    dc_hit = 1'b0; mem_ack = 1'b0; except = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [255:0] all_out;
    @(negedge clk);
    rst_n = 1'b0;
    st_req = 1'b1; st_addr = 16'hFFFF; st_data = 32'hFFFF_FFFF; st_size = 2'd3;
    ld_req = 1'b1; ld_lq_idx = 4'd5; ld_addr = 16'hFFFF; ld_size = 2'd3;
    dc_hit = 1'b1; mem_ack = 1'b1; except = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #2;
      all_out = '0;
      all_out[197:0] = {st_ack, ld_ack, wr_en, wr_tag, wr_idx, wr_offset, wr_data, wr_size, rd_en, rd_tag, rd_idx,
                        rd_offset, rd_size, rd_gnt, mem_req, mem_addr, dc_feedback, mem_feedback, 64'h0};
      checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_outputs_zero cycle=%0d got=%0h exp=0", c, all_out); end
      checks++; if (st_ack !== 1'b0) begin errors++; $display("FAIL reset_st_ack got=%0b exp=0", st_ack); end
      checks++; if (rd_gnt !== 16'h0) begin errors++; $display("FAIL reset_rd_gnt got=%0h exp=0", rd_gnt); end
      @(negedge clk);
    end
    drive_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_hit();
    @(negedge clk);
    drive_idle();
    ld_req = 1'b1; ld_lq_idx = 4'd5; ld_addr = 16'h1234; ld_size = 2'd2; dc_hit = 1'b1;
    #2;
    checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL hit_rd_en got=%0b exp=1", rd_en); end
    checks++; if (ld_ack !== 1'b1) begin errors++; $display("FAIL hit_ld_ack got=%0b exp=1", ld_ack); end
    checks++; if (rd_tag !== 8'h12) begin errors++; $display("FAIL hit_rd_tag got=%0h exp=12", rd_tag); end
    checks++; if (rd_idx !== 5'h06) begin errors++; $display("FAIL hit_rd_idx got=%0h exp=06", rd_idx); end
    checks++; if (rd_offset !== 3'h4) begin errors++; $display("FAIL hit_rd_offset got=%0h exp=4", rd_offset); end
    checks++; if (rd_size !== 2'd2) begin errors++; $display("FAIL hit_rd_size got=%0h exp=2", rd_size); end
    checks++; if (rd_gnt !== 16'h0020) begin errors++; $display("FAIL hit_rd_gnt got=%0h exp=0020", rd_gnt); end
    checks++; if (dc_feedback !== 16'h0020) begin errors++; $display("FAIL hit_dc_feedback got=%0h exp=0020", dc_feedback); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL hit_wr_en got=%0b exp=0", wr_en); end
    @(negedge clk);
    drive_idle();
    ld_req = 1'b1; ld_lq_idx = 4'd0; ld_addr = 16'h0008; dc_hit = 1'b1;
    #2;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL hit_stays_idle_mem_req got=%0b exp=0", mem_req); end
    checks++; if (ld_ack !== 1'b1) begin errors++; $display("FAIL hit_next_load_ack got=%0b exp=1", ld_ack); end
    checks++; if (dc_feedback !== 16'h0001) begin errors++; $display("FAIL hit_next_dc_feedback got=%0h exp=0001", dc_feedback); end
  endtask

  task automatic test_miss();
    @(negedge clk);
    drive_idle();
    ld_req = 1'b1; ld_lq_idx = 4'd3; ld_addr = 16'h00A8; dc_hit = 1'b0;
    #2;
    checks++; if (ld_ack !== 1'b1) begin errors++; $display("FAIL miss_ld_ack got=%0b exp=1", ld_ack); end
    checks++; if (dc_feedback !== 16'h0) begin errors++; $display("FAIL miss_dc_feedback got=%0h exp=0", dc_feedback); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL miss_mem_req_grant_cycle got=%0b exp=0", mem_req); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      drive_idle();
      ld_req = 1'b1; ld_lq_idx = 4'd9; ld_addr = 16'h5555; dc_hit = 1'b1;
      if (c == 2) begin st_req = 1'b1; st_addr = 16'hABCD; st_data = 32'hDEAD_BEEF; st_size = 2'd2; end
      if (c == 4) mem_ack = 1'b1;
      #2;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL miss_mem_req cycle=%0d got=%0b exp=1", c, mem_req); end
      checks++; if (mem_addr !== 16'h00A8) begin errors++; $display("FAIL miss_mem_addr cycle=%0d got=%0h exp=00a8", c, mem_addr); end
      checks++; if (ld_ack !== 1'b0 || rd_en !== 1'b0) begin errors++; $display("FAIL miss_load_blocked cycle=%0d got=%0b exp=0", c, ld_ack); end
      if (c == 2) begin
        checks++; if (st_ack !== 1'b1) begin errors++; $display("FAIL miss_store_ack got=%0b exp=1", st_ack); end
        checks++; if ({wr_tag, wr_idx, wr_offset} !== {8'hAB, 5'h19, 3'h5}) begin errors++; $display("FAIL miss_store_fields got=%0h/%0h/%0h exp=ab/19/5", wr_tag, wr_idx, wr_offset); end
        checks++; if (wr_data !== 32'hDEAD_BEEF || wr_size !== 2'd2) begin errors++; $display("FAIL miss_store_data got=%0h/%0d exp=deadbeef/2", wr_data, wr_size); end
      end
      checks++; if (mem_feedback !== ((c == 4) ? 16'h0008 : 16'h0)) begin errors++; $display("FAIL miss_mem_feedback cycle=%0d got=%0h exp=%0h", c, mem_feedback, (c == 4) ? 16'h0008 : 16'h0); end
    end
    @(negedge clk);
    drive_idle();
    ld_req = 1'b1; ld_lq_idx = 4'd1; ld_addr = 16'h0100; dc_hit = 1'b1;
    #2;
    checks++; if (ld_ack !== 1'b1) begin errors++; $display("FAIL miss_after_fill_ld_ack got=%0b exp=1", ld_ack); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL miss_after_fill_mem_req got=%0b exp=0", mem_req); end
  endtask

  task automatic test_starve();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      drive_idle();
      st_req = 1'b1; st_addr = 16'(c * 8); st_data = 32'(c);
      ld_req = 1'b1; ld_lq_idx = 4'd2; ld_addr = 16'h0040; dc_hit = 1'b1;
      #2;
      checks++; if (ld_ack !== (c % 5 == 4)) begin errors++; $display("FAIL starve_ld_ack cycle=%0d got=%0b exp=%0b", c + 1, ld_ack, c % 5 == 4); end
      checks++; if (st_ack !== (c % 5 != 4)) begin errors++; $display("FAIL starve_st_ack cycle=%0d got=%0b exp=%0b", c + 1, st_ack, c % 5 != 4); end
      checks++; if (wr_en && rd_en) begin errors++; $display("FAIL starve_exclusive cycle=%0d got=both exp=one", c + 1); end
    end
  endtask

  task automatic test_squash();
    @(negedge clk);
    drive_idle();
    ld_req = 1'b1; ld_lq_idx = 4'd7; ld_addr = 16'h3C10; dc_hit = 1'b0;
    #2;
    checks++; if (ld_ack !== 1'b1) begin errors++; $display("FAIL squash_miss_ack got=%0b exp=1", ld_ack); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      drive_idle();
      if (c == 1) begin except = 1'b1; st_req = 1'b1; st_addr = 16'h0F00; end
      if (c == 2) begin except = 1'b1; ld_req = 1'b1; dc_hit = 1'b1; end
      if (c == 3) begin mem_ack = 1'b1; ld_req = 1'b1; dc_hit = 1'b1; end
      #2;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL squash_mem_req cycle=%0d got=%0b exp=1", c, mem_req); end
      checks++; if (mem_feedback !== 16'h0) begin errors++; $display("FAIL squash_mem_feedback cycle=%0d got=%0h exp=0", c, mem_feedback); end
      checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL squash_load_blocked cycle=%0d got=%0b exp=0", c, ld_ack); end
      if (c == 1) begin
        checks++; if (st_ack !== 1'b1) begin errors++; $display("FAIL squash_store_in_except got=%0b exp=1", st_ack); end
      end
    end
    @(negedge clk);
    drive_idle();
    ld_req = 1'b1; ld_lq_idx = 4'd4; ld_addr = 16'h0200; dc_hit = 1'b1;
    #2;
    checks++; if (dc_feedback !== 16'h0010) begin errors++; $display("FAIL squash_idle_hit got=%0h exp=0010", dc_feedback); end
    @(negedge clk);
    drive_idle();
    ld_req = 1'b1; ld_lq_idx = 4'd7; ld_addr = 16'h3C18; dc_hit = 1'b0;
    #2;
    checks++; if (ld_ack !== 1'b1) begin errors++; $display("FAIL squash2_miss_ack got=%0b exp=1", ld_ack); end
    @(negedge clk);
    drive_idle();
    except = 1'b1; mem_ack = 1'b1;
    #2;
    checks++; if (mem_feedback !== 16'h0) begin errors++; $display("FAIL squash2_same_cycle_feedback got=%0h exp=0", mem_feedback); end
    @(negedge clk);
    drive_idle();
    ld_req = 1'b1; ld_lq_idx = 4'd6; ld_addr = 16'h0300; dc_hit = 1'b1;
    #2;
    checks++; if (ld_ack !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL squash2_back_idle got=%0b/%0b exp=1/0", ld_ack, mem_req); end
  endtask

  task automatic test_reset_mid_miss();
    @(negedge clk);
    drive_idle();
    ld_req = 1'b1; ld_lq_idx = 4'd2; ld_addr = 16'h7777; dc_hit = 1'b0;
    #2;
    checks++; if (ld_ack !== 1'b1) begin errors++; $display("FAIL rmm_miss_ack got=%0b exp=1", ld_ack); end
    @(negedge clk);
    drive_idle();
    #2;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmm_mem_req_before got=%0b exp=1", mem_req); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmm_mem_req_async got=%0b exp=0", mem_req); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL rmm_mem_addr_async got=%0h exp=0", mem_addr); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; ld_req = 1'b1; ld_lq_idx = 4'd11; ld_addr = 16'h0400; dc_hit = 1'b1;
    #2;
    checks++; if (mem_feedback !== 16'h0) begin errors++; $display("FAIL rmm_stale_ack_feedback got=%0h exp=0", mem_feedback); end
    checks++; if (ld_ack !== 1'b1) begin errors++; $display("FAIL rmm_new_load got=%0b exp=1", ld_ack); end
    checks++; if (dc_feedback !== 16'h0800) begin errors++; $display("FAIL rmm_new_load_feedback got=%0h exp=0800", dc_feedback); end
  endtask

  // Model: miss_busy 0 = none, 1 = live miss, 2 = squashed miss.
  task automatic test_random(input int n);
    int          miss_busy = 0;
    int          miss_entry = 0;
    logic [15:0] miss_line = '0;
    int          losses = 0;
    bit          can_load, load_wins, exp_st;
    logic [15:0] exp_gnt, exp_dcfb, exp_mfb, unit;
    unit = 16'h0001;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      st_req = ($urandom_range(0, 99) < 55); st_addr = 16'($urandom); st_data = $urandom; st_size = 2'($urandom);
      ld_req = ($urandom_range(0, 99) < 70); ld_lq_idx = 4'($urandom); ld_addr = 16'($urandom); ld_size = 2'($urandom);
      dc_hit = ($urandom_range(0, 99) < 50); mem_ack = ($urandom_range(0, 99) < 30); except = ($urandom_range(0, 99) < 10);
      #2;
      can_load  = (miss_busy == 0) && ld_req && !except;
      load_wins = can_load && (!st_req || losses >= STARVE_LIMIT);
      exp_st    = st_req && !load_wins;
      exp_gnt   = load_wins ? (unit << ld_lq_idx) : 16'h0;
      exp_dcfb  = (load_wins && dc_hit) ? exp_gnt : 16'h0;
      exp_mfb   = (miss_busy == 1 && mem_ack && !except) ? (unit << miss_entry) : 16'h0;
      checks++; if (st_ack !== exp_st || wr_en !== exp_st) begin errors++; $display("FAIL rand_st_ack cycle=%0d got=%0b exp=%0b", c, st_ack, exp_st); end
      checks++; if (ld_ack !== load_wins || rd_en !== load_wins) begin errors++; $display("FAIL rand_ld_ack cycle=%0d got=%0b exp=%0b", c, ld_ack, load_wins); end
      checks++; if (rd_gnt !== exp_gnt) begin errors++; $display("FAIL rand_rd_gnt cycle=%0d got=%0h exp=%0h", c, rd_gnt, exp_gnt); end
      checks++; if (dc_feedback !== exp_dcfb) begin errors++; $display("FAIL rand_dc_feedback cycle=%0d got=%0h exp=%0h", c, dc_feedback, exp_dcfb); end
      checks++; if (mem_feedback !== exp_mfb) begin errors++; $display("FAIL rand_mem_feedback cycle=%0d got=%0h exp=%0h", c, mem_feedback, exp_mfb); end
      checks++; if (mem_req !== (miss_busy != 0)) begin errors++; $display("FAIL rand_mem_req cycle=%0d got=%0b exp=%0b", c, mem_req, miss_busy != 0); end
      if (miss_busy != 0) begin
        checks++; if (mem_addr !== miss_line) begin errors++; $display("FAIL rand_mem_addr cycle=%0d got=%0h exp=%0h", c, mem_addr, miss_line); end
      end
      if (exp_st) begin
        checks++; if ({wr_tag, wr_idx, wr_offset, wr_data, wr_size} !== {st_addr, st_data, st_size}) begin errors++; $display("FAIL rand_wr_fields cycle=%0d got=%0h exp=%0h", c, {wr_tag, wr_idx, wr_offset, wr_data, wr_size}, {st_addr, st_data, st_size}); end
      end
      if (load_wins) begin
        checks++; if ({rd_tag, rd_idx, rd_offset, rd_size} !== {ld_addr, ld_size}) begin errors++; $display("FAIL rand_rd_fields cycle=%0d got=%0h exp=%0h", c, {rd_tag, rd_idx, rd_offset, rd_size}, {ld_addr, ld_size}); end
      end
      if (miss_busy == 1) begin
        if (mem_ack) miss_busy = 0;
        else if (except) miss_busy = 2;
      end else if (miss_busy == 2) begin
        if (mem_ack) miss_busy = 0;
      end else if (load_wins && !dc_hit) begin
        miss_busy = 1; miss_entry = int'(ld_lq_idx); miss_line = ld_addr;
      end
      if (load_wins || !ld_req) losses = 0;
      else if (can_load) losses++;
    end
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    test_reset();
    do_reset();
    test_hit();
    do_reset();
    test_miss();
    do_reset();
    test_starve();
    do_reset();
    test_squash();
    do_reset();
    test_reset_mid_miss();
    do_reset();
    test_random(3000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
